coherent_sampler_counter: RTL
=============================

# coherent_sampler_counter

Producer side of the CSCnt/CSReq/CSAck handshake consumed by the configuration-matching controller. It measures the period of the coherent-sampler beat signal in clk cycles: the beat is RO0 sampled by the RO1-derived clk. It deglitches beat rising edges, captures each full period into CSCnt, and issues a one-cycle CSReq per valid measurement. It withholds new measurements until the consumer acknowledges.

## Interface
Parameters:
- CSCntLength, 16, width of the period counter and CSCnt.
- FiltLen, 4, minimum number of consecutive low beat cycles required before a rising edge qualifies; range 1..255.

Ports:
- clk  in  1  sampling clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- beat  in  1  coherent-sampler output, already in the clk domain.
- restart  in  1  one-cycle pulse; discards the current partial measurement, for example after an RO configuration change.
- CSAck  in  1  consumer acknowledge; a high level in any cycle marks the pending CSCnt as read.
- CSCnt  out  CSCntLength  last captured period in clk cycles; saturates at all-ones.
- CSReq  out  1  one-cycle pulse; CSCnt is valid and stays stable until CSAck.
- pending  out  1  high from CSReq until CSAck is seen.
- satFlag  out  1  sticky; set when any captured period saturated.

## Operation
- Low-run counter lowRun, 8 bits: increments while beat=0 and saturates at FiltLen; clears when beat=1.
- Qualified edge (qe): beat=1 and lowRun==FiltLen in the same cycle. Glitches shorter than FiltLen low cycles do not form an edge.
- Period counter cnt, CSCntLength bits: increments every cycle and saturates at all-ones. On qe, cnt is loaded with 1.
- armed flag: set by the first qe after reset or restart. That first qe only starts counting and never captures.
- FSM states:
  - IDLE: not armed. On qe, go to COUNT.
  - COUNT: armed, nothing pending. On qe, CSCnt <= cnt, CSReq <= 1 for one cycle, pending <= 1, satFlag |= (cnt==all-ones), go to WAIT.
  - WAIT: pending. On CSAck=1, pending <= 0 and go to DISCARD. On qe, the measurement is dropped: cnt is reloaded with 1, CSCnt is unchanged and no CSReq is issued.
  - DISCARD: the period that was running when the ack arrived is partial. On the next qe, reload cnt and go to COUNT without capture.
- restart in any state: pending is kept if already set, armed <= 0, cnt <= 0, lowRun <= 0. The next state is IDLE, or WAIT if pending; a WAIT entered this way exits to IDLE on CSAck.
- Simultaneous qe and CSAck in WAIT: the ack takes effect, the qe starts a new count, and the state goes to COUNT. That qe serves as the discard edge.
- Simultaneous restart and qe: restart wins and the qe is ignored.
- CSAck while not pending is ignored.
- Reset values: CSCnt=0, CSReq=0, pending=0, satFlag=0, state IDLE, cnt=0, lowRun=0. Reset mid-WAIT drops the pending value silently.

## Timing
- All outputs are registered. A qe in cycle n gives CSReq=1 and the new CSCnt in cycle n+1. CSReq is 0 at n+2 regardless of CSAck.
- For beat qe's at cycles t0 and t0+P, CSCnt = P if P < 2^CSCntLength, otherwise all-ones.
- The consumer asserts CSAck in the cycle after CSReq. pending clears one cycle after the ack.
- Because CSReq is a single-cycle pulse, a consumer that re-samples CSReq every cycle counts each measurement exactly once.
- Maximum measurement rate is one per two beat periods (capture, then discard).

## Test plan
- Clean beat with period 37 (18 cycles high, 19 low), FiltLen=4, ack one cycle after CSReq: the first qe gives no CSReq; after that every other period gives CSCnt=37, each CSReq 1 cycle wide.
- Beat with a 2-cycle low glitch inside the high phase, FiltLen=4: no extra qe; CSCnt still equals the true period.
- CSAck withheld for 5 periods: no new CSReq; CSCnt stays at the first value and pending stays 1. Ack then given: the next capture occurs two qe's later.
- Period 70000 with CSCntLength=16: CSCnt=65535, satFlag=1, and satFlag stays 1 after later normal periods.
- restart pulse mid-COUNT: the next qe produces no CSReq; the following qe captures the exact period measured from it.
- rst asserted during WAIT, then released: all outputs return to 0. The first two qe's after release produce only one CSReq, at the second qe.

Source files
------------

// File: rtl/coherent_sampler_counter.sv
// Measures the coherent-sampler beat period in clk cycles and hands each
// measurement to the consumer over the CSCnt/CSReq/CSAck handshake.
module coherent_sampler_counter #(
  parameter int unsigned CSCntLength = 16,
  parameter int unsigned FiltLen     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beat,
  input  logic                   restart,
  input  logic                   CSAck,
  output logic [CSCntLength-1:0] CSCnt,
  output logic                   CSReq,
  output logic                   pending,
  output logic                   satFlag
);

  localparam int unsigned LowW = 8;
  localparam logic [LowW-1:0]        FiltMax = LowW'(FiltLen);
  localparam logic [CSCntLength-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [LowW-1:0]        low_run, low_run_nxt;
  logic [CSCntLength-1:0] cnt, cnt_nxt;
  logic [CSCntLength-1:0] cs_cnt_nxt;
  logic                   cs_req_nxt;
  logic                   pending_nxt;
  logic                   sat_nxt;
  logic                   rst_wait, rst_wait_nxt;
  logic                   qe;

  // Rising edge counts only after a sufficiently long low run (deglitch).
  assign qe = beat && (low_run == FiltMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      low_run  <= '0;
      cnt      <= '0;
      CSCnt    <= '0;
      CSReq    <= 1'b0;
      pending  <= 1'b0;
      satFlag  <= 1'b0;
      rst_wait <= 1'b0;
    end else begin
      state    <= state_nxt;
      low_run  <= low_run_nxt;
      cnt      <= cnt_nxt;
      CSCnt    <= cs_cnt_nxt;
      CSReq    <= cs_req_nxt;
      pending  <= pending_nxt;
      satFlag  <= sat_nxt;
      rst_wait <= rst_wait_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    low_run_nxt  = low_run;
    cnt_nxt      = cnt;
    cs_cnt_nxt   = CSCnt;
    cs_req_nxt   = 1'b0;
    pending_nxt  = pending;
    sat_nxt      = satFlag;
    rst_wait_nxt = rst_wait;

    if (beat) begin
      low_run_nxt = '0;
    end else if (low_run != FiltMax) begin
      low_run_nxt = low_run + LowW'(1);
    end

    if (cnt != CntMax) begin
      cnt_nxt = cnt + CSCntLength'(1);
    end

    if (restart) begin
      // Drop the partial period but keep an unread value on offer.
      low_run_nxt  = '0;
      cnt_nxt      = '0;
      pending_nxt  = pending && !CSAck;
      rst_wait_nxt = pending_nxt;
      state_nxt    = pending_nxt ? WAIT : IDLE;
    end else begin
      if (qe) begin
        cnt_nxt = CSCntLength'(1);
      end
      unique case (state)
        IDLE: begin
          if (qe) state_nxt = COUNT;
        end
        COUNT: begin
          if (qe) begin
            cs_cnt_nxt  = cnt;
            cs_req_nxt  = 1'b1;
            pending_nxt = 1'b1;
            if (cnt == CntMax) sat_nxt = 1'b1;
            state_nxt   = WAIT;
          end
        end
        WAIT: begin
          // A coincident edge closes the discarded partial period at once.
          if (CSAck) begin
            pending_nxt  = 1'b0;
            rst_wait_nxt = 1'b0;
            if (qe)            state_nxt = COUNT;
            else if (rst_wait) state_nxt = IDLE;
            else               state_nxt = DISCARD;
          end
        end
        DISCARD: begin
          if (qe) state_nxt = COUNT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
